// File: rtl/cc_collision_monitor.sv
// cc_collision_monitor
//
// Registered multi-player collision monitor for the row-scrolling game datapath.
// On each frame tick it compares the obstacle row at the player line (fila0) with
// every player's position over the column window [COL_HI:COL_LO]. Each player has
// its own lives counter and ALIVE/HOLD/DEAD state. Game over is flagged once every
// player is dead.
//
// Optional feature macro: CC_COLLISION_HOLDOFF_EN
//   defined   - after a non-fatal hit the player enters HOLD and is immune for
//               HOLDOFF ticks
//   undefined - there is no HOLD state and no holdoff counter, so every
//               overlapping tick in ALIVE costs a life
//
// Ports:
//   CC_COLLISION_MONITOR_CLOCK_50     in   clock, rising edge
//   CC_COLLISION_MONITOR_RESET_InLow  in   asynchronous active-low reset
//   CC_COLLISION_MONITOR_restart      in   synchronous game restart; wins over tick
//   CC_COLLISION_MONITOR_tick         in   one-cycle frame strobe
//   CC_COLLISION_MONITOR_fila0        in   obstacle row at the player line
//   CC_COLLISION_MONITOR_posjug       in   player p at [p*DATAWIDTH +: DATAWIDTH]
//   CC_COLLISION_MONITOR_OutBUS       out  per-player clear flag from the last tick
//   CC_COLLISION_MONITOR_hit          out  one-cycle pulse per lost life
//   CC_COLLISION_MONITOR_lives        out  remaining lives, player p at [p*LW +: LW]
//   CC_COLLISION_MONITOR_dead         out  player has no lives left
//   CC_COLLISION_MONITOR_gameover     out  all players dead
module cc_collision_monitor #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned PLAYERS   = 2,
    parameter int unsigned COL_LO    = 4,
    parameter int unsigned COL_HI    = 7,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned HOLDOFF   = 4,
    localparam int unsigned LW       = $clog2(LIVES + 1)
) (
    input  logic                           CC_COLLISION_MONITOR_CLOCK_50,
    input  logic                           CC_COLLISION_MONITOR_RESET_InLow,
    input  logic                           CC_COLLISION_MONITOR_restart,
    input  logic                           CC_COLLISION_MONITOR_tick,
    input  logic [DATAWIDTH-1:0]           CC_COLLISION_MONITOR_fila0,
    input  logic [PLAYERS*DATAWIDTH-1:0]   CC_COLLISION_MONITOR_posjug,
    output logic [PLAYERS-1:0]             CC_COLLISION_MONITOR_OutBUS,
    output logic [PLAYERS-1:0]             CC_COLLISION_MONITOR_hit,
    output logic [PLAYERS*LW-1:0]          CC_COLLISION_MONITOR_lives,
    output logic [PLAYERS-1:0]             CC_COLLISION_MONITOR_dead,
    output logic                           CC_COLLISION_MONITOR_gameover
);

    localparam int unsigned WinW = COL_HI - COL_LO + 1;
`ifdef CC_COLLISION_HOLDOFF_EN
    localparam int unsigned HW = $clog2(HOLDOFF + 1);
`endif

    // Elaboration-time parameter legality check.
    if (COL_LO > COL_HI || COL_HI >= DATAWIDTH || LIVES < 1 || HOLDOFF < 1 ||
        PLAYERS < 1) begin : genBadParams
        $error("cc_collision_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        StAlive = 2'd0,
        StHold  = 2'd1,
        StDead  = 2'd2
    } playerStateT;

    // Only the window bits are compared; the rest of the row/position buses are
    // intentionally ignored.
    logic unusedBits;
    assign unusedBits = ^{CC_COLLISION_MONITOR_fila0, CC_COLLISION_MONITOR_posjug};

    logic [WinW-1:0]    rowWin;
    logic [PLAYERS-1:0] deadNext;
    logic               gameoverQ;

    assign rowWin = CC_COLLISION_MONITOR_fila0[COL_HI:COL_LO];

    for (genvar p = 0; p < PLAYERS; p++) begin : genPlayer
        playerStateT     stateQ, stateD;
        logic [LW-1:0]   livesQ, livesD;
        logic            clearQ, clearD;
        logic            hitQ, hitD;
        logic [WinW-1:0] posWin;
        logic            overlap;
`ifdef CC_COLLISION_HOLDOFF_EN
        logic [HW-1:0]   holdQ, holdD;
`endif

        assign posWin  = CC_COLLISION_MONITOR_posjug[p*DATAWIDTH + COL_LO +: WinW];
        assign overlap = |(rowWin & posWin);

        always_comb begin
            stateD = stateQ;
            livesD = livesQ;
            clearD = clearQ;
            hitD   = 1'b0;
`ifdef CC_COLLISION_HOLDOFF_EN
            holdD  = holdQ;
`endif
            if (CC_COLLISION_MONITOR_restart) begin
                // Any tick in the same cycle is discarded.
                stateD = StAlive;
                livesD = LW'(LIVES);
                clearD = 1'b1;
`ifdef CC_COLLISION_HOLDOFF_EN
                holdD  = '0;
`endif
            end else if (CC_COLLISION_MONITOR_tick) begin
                case (stateQ)
                    StAlive: begin
                        clearD = ~overlap;
                        if (overlap) begin
                            hitD = 1'b1;
                            if (livesQ <= LW'(1)) begin
                                // Last life: saturate at zero and stop.
                                livesD = '0;
                                stateD = StDead;
                                clearD = 1'b0;
                            end else begin
                                livesD = livesQ - LW'(1);
`ifdef CC_COLLISION_HOLDOFF_EN
                                stateD = StHold;
                                holdD  = HW'(HOLDOFF);
`endif
                            end
                        end
                    end
`ifdef CC_COLLISION_HOLDOFF_EN
                    StHold: begin
                        // Immune tick: clear flag still tracks the overlap.
                        clearD = ~overlap;
                        if (holdQ != '0) begin
                            holdD = holdQ - HW'(1);
                        end
                        if (holdQ <= HW'(1)) begin
                            stateD = StAlive;
                        end
                    end
`endif
                    StDead: begin
                        clearD = 1'b0;
                    end
                    default: begin
                        stateD = StAlive;
                    end
                endcase
            end
        end

        always_ff @(posedge CC_COLLISION_MONITOR_CLOCK_50 or
                    negedge CC_COLLISION_MONITOR_RESET_InLow) begin
            if (!CC_COLLISION_MONITOR_RESET_InLow) begin
                stateQ <= StAlive;
                livesQ <= LW'(LIVES);
                clearQ <= 1'b1;
                hitQ   <= 1'b0;
`ifdef CC_COLLISION_HOLDOFF_EN
                holdQ  <= '0;
`endif
            end else begin
                stateQ <= stateD;
                livesQ <= livesD;
                clearQ <= clearD;
                hitQ   <= hitD;
`ifdef CC_COLLISION_HOLDOFF_EN
                holdQ  <= holdD;
`endif
            end
        end

        assign deadNext[p]                        = (stateD == StDead);
        assign CC_COLLISION_MONITOR_OutBUS[p]     = clearQ;
        assign CC_COLLISION_MONITOR_hit[p]        = hitQ;
        assign CC_COLLISION_MONITOR_lives[p*LW +: LW] = livesQ;
        assign CC_COLLISION_MONITOR_dead[p]       = (stateQ == StDead);
    end

    // Registered from the next-state so it lines up with dead on the same edge.
    always_ff @(posedge CC_COLLISION_MONITOR_CLOCK_50 or
                negedge CC_COLLISION_MONITOR_RESET_InLow) begin
        if (!CC_COLLISION_MONITOR_RESET_InLow) begin
            gameoverQ <= 1'b0;
        end else begin
            gameoverQ <= &deadNext;
        end
    end

    assign CC_COLLISION_MONITOR_gameover = gameoverQ;

endmodule

// File: tb/tb_cc_collision_monitor.sv
module tb_cc_collision_monitor;

    logic        clk;
    logic        clkRun;
    logic        rstN;
    logic        restart;
    logic        tick;
    logic [7:0]  fila0;
    logic [15:0] posjug;
    logic [1:0]  outBus;
    logic [1:0]  hit;
    logic [3:0]  lives;
    logic [1:0]  dead;
    logic        gameover;

    int nChecks = 0;
    int nFail   = 0;

`ifdef CC_COLLISION_HOLDOFF_EN
    localparam int HitGap = 5;  // one hit, then HOLDOFF immune ticks
`else
    localparam int HitGap = 1;
`endif

    cc_collision_monitor dut (
        .CC_COLLISION_MONITOR_CLOCK_50    (clk),
        .CC_COLLISION_MONITOR_RESET_InLow (rstN),
        .CC_COLLISION_MONITOR_restart     (restart),
        .CC_COLLISION_MONITOR_tick        (tick),
        .CC_COLLISION_MONITOR_fila0       (fila0),
        .CC_COLLISION_MONITOR_posjug      (posjug),
        .CC_COLLISION_MONITOR_OutBUS      (outBus),
        .CC_COLLISION_MONITOR_hit         (hit),
        .CC_COLLISION_MONITOR_lives       (lives),
        .CC_COLLISION_MONITOR_dead        (dead),
        .CC_COLLISION_MONITOR_gameover    (gameover)
    );

    always #5 if (clkRun) clk = ~clk;

    typedef struct {
        logic        restart;
        logic        tick;
        logic [7:0]  fila0;
        logic [15:0] posjug;
        logic [1:0]  outBus;
        logic [1:0]  hit;
        logic [3:0]  lives;
        logic [1:0]  dead;
        logic        gameover;
    } vecT;

    vecT vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [1:0] eOut, input logic [1:0] eHit,
                            input logic [3:0] eLives, input logic [1:0] eDead, input logic eGo);
        chk({name, ".OutBUS"},   32'(outBus),   32'(eOut));
        chk({name, ".hit"},      32'(hit),      32'(eHit));
        chk({name, ".lives"},    32'(lives),    32'(eLives));
        chk({name, ".dead"},     32'(dead),     32'(eDead));
        chk({name, ".gameover"}, 32'(gameover), 32'(eGo));
    endtask

    // Drive one cycle of inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic r, input logic t, input logic [7:0] f, input logic [15:0] p);
        restart = r;
        tick    = t;
        fila0   = f;
        posjug  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   tick  fila0  posjug     OutBUS hit    lives  dead   go
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h0F, 16'h0001, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hF0, 16'h0F0F, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hF0, 16'h0110, 2'b10, 2'b01, 4'hE, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'hFF, 16'hFFFF, 2'b10, 2'b00, 4'hE, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h80, 16'h8040, 2'b01, 2'b10, 4'hB, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'hFF, 16'hFFFF, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h20, 16'h2020, 2'b00, 2'b11, 4'hA, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 16'hFFFF, 2'b11, 2'b00, 4'hA, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 16'h0000, 2'b11, 2'b00, 4'hF, 2'b00, 1'b0};

        clk     = 1'b0;
        clkRun  = 1'b0;
        rstN    = 1'b1;
        restart = 1'b0;
        tick    = 1'b0;
        fila0   = 8'h00;
        posjug  = 16'h0000;

        // Reset with the clock stopped.
        #2 rstN = 1'b0;
        #4 checkAll("reset", 2'b11, 2'b00, 4'hF, 2'b00, 1'b0);
        #1 rstN = 1'b1;
        clkRun = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].restart, vecs[i].tick, vecs[i].fila0, vecs[i].posjug);
            checkAll($sformatf("vec%0d", i), vecs[i].outBus, vecs[i].hit, vecs[i].lives,
                     vecs[i].dead, vecs[i].gameover);
        end

        // Holdoff: player 0 overlaps on six consecutive ticks, player 1 never.
        for (int i = 0; i < 6; i++) begin
            int nHits;
            logic eHit;
            nHits = (i / HitGap + 1 > 3) ? 3 : i / HitGap + 1;
            eHit  = (i % HitGap == 0) && (i / HitGap + 1 <= 3);
            step(1'b0, 1'b1, 8'hF0, 16'h0110);
            checkAll($sformatf("hold%0d", i), 2'b10, {1'b0, eHit}, {2'd3, 2'(3 - nHits)},
                     {1'b0, nHits == 3}, 1'b0);
        end

        // Game over: both players overlap until dead, then extra ticks are ignored.
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        checkAll("restart1", 2'b11, 2'b00, 4'hF, 2'b00, 1'b0);
        for (int k = 0; k <= 2 * HitGap + 2; k++) begin
            int nHits;
            logic eHit;
            logic [1:0] l;
            nHits = (k / HitGap + 1 > 3) ? 3 : k / HitGap + 1;
            eHit  = (k % HitGap == 0) && (k <= 2 * HitGap);
            l     = 2'(3 - nHits);
            step(1'b0, 1'b1, 8'hFF, 16'hFFFF);
            checkAll($sformatf("go%0d", k), 2'b00, {eHit, eHit}, {l, l},
                     {2{k >= 2 * HitGap}}, k >= 2 * HitGap);
        end
        step(1'b0, 1'b1, 8'h00, 16'h0000);
        checkAll("deadNoOverlap", 2'b00, 2'b00, 4'h0, 2'b11, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 16'hFFFF);
        checkAll("restartWithTick", 2'b11, 2'b00, 4'hF, 2'b00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 16'h0000);
        checkAll("afterRestart", 2'b11, 2'b00, 4'hF, 2'b00, 1'b0);

        // Reset in the middle of HOLD, then an immediate hit after release.
        step(1'b0, 1'b1, 8'hF0, 16'h0110);
        checkAll("midHit", 2'b10, 2'b01, 4'hE, 2'b00, 1'b0);
        step(1'b0, 1'b1, 8'hF0, 16'h0110);
        chk("midSecond.lives", 32'(lives), (HitGap > 1) ? 32'hE : 32'hD);
        #2 rstN = 1'b0;
        #1 checkAll("asyncReset", 2'b11, 2'b00, 4'hF, 2'b00, 1'b0);
        #2 rstN = 1'b1;
        step(1'b0, 1'b1, 8'hF0, 16'h0110);
        checkAll("postResetHit", 2'b10, 2'b01, 4'hE, 2'b00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 16'h0000);
        checkAll("postResetIdle", 2'b10, 2'b00, 4'hE, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/cc_collision_monitor.md
# cc_collision_monitor

Registered, multi-player collision monitor for the row-scrolling game datapath. On every frame tick it compares the obstacle row arriving at the player line against each player's position over a configurable column window. It then keeps per-player lives, a post-hit invincibility window and dead/game-over status. It sits between the row shifter (source of `fila0`) and the game-control FSM / display, and supersedes the per-player combinational position comparators.

## Interface

- `DATAWIDTH`, 8, width of one row and of one player position vector
- `PLAYERS`, 2, number of independent players
- `COL_LO`, 4, lowest column checked for overlap
- `COL_HI`, 7, highest column checked for overlap
- `LIVES`, 3, lives per player after reset/restart
- `HOLDOFF`, 4, invincibility length in ticks after a non-fatal hit
- Legal values: `0 <= COL_LO <= COL_HI < DATAWIDTH`, `LIVES >= 1`, `HOLDOFF >= 1`
- Derived widths: `LW = clog2(LIVES+1)`, `HW = clog2(HOLDOFF+1)`

Ports:

- `CC_COLLISION_MONITOR_CLOCK_50` in, 1, single clock, rising edge
- `CC_COLLISION_MONITOR_RESET_InLow` in, 1, asynchronous active-low reset
- `CC_COLLISION_MONITOR_restart` in, 1, synchronous active-high game restart
- `CC_COLLISION_MONITOR_tick` in, 1, one-cycle frame strobe; the comparison is sampled only on this cycle
- `CC_COLLISION_MONITOR_fila0` in, DATAWIDTH, obstacle row at the player line
- `CC_COLLISION_MONITOR_posjug` in, PLAYERS*DATAWIDTH, player p at `[p*DATAWIDTH +: DATAWIDTH]`
- `CC_COLLISION_MONITOR_OutBUS` out, PLAYERS, per-player clear flag: 1 = no overlap at the last tick
- `CC_COLLISION_MONITOR_hit` out, PLAYERS, one-cycle pulse when a life is lost
- `CC_COLLISION_MONITOR_lives` out, PLAYERS*LW, remaining lives, player p at `[p*LW +: LW]`
- `CC_COLLISION_MONITOR_dead` out, PLAYERS, player has 0 lives
- `CC_COLLISION_MONITOR_gameover` out, 1, all players dead

## Operation

- Overlap for player p is `|(fila0[COL_HI:COL_LO] & pos_p[COL_HI:COL_LO])`. Bits outside the window never cause a hit.
- Each player has an independent FSM with states ALIVE, HOLD and DEAD, a lives counter (LW bits) and a holdoff counter (HW bits).
- **ALIVE**, tick with overlap:
  - Lives decrement by 1 and `hit[p]` pulses.
  - If lives were 1, go to DEAD.
  - Otherwise go to HOLD and load the holdoff counter with HOLDOFF (macro on), or stay in ALIVE (macro off).
- **HOLD**, every tick:
  - The holdoff counter decrements. Overlaps are ignored: no hit, no decrement.
  - On the tick where the counter equals 1, go to ALIVE. Exactly HOLDOFF ticks are immune.
- **DEAD**:
  - Absorbing until restart. Ticks are ignored.
  - `OutBUS[p]` is forced to 0 and `dead[p]` is 1.
- `OutBUS[p]` updates on every tick to `~overlap` in ALIVE and HOLD, including immune ticks. Between ticks it holds its value.
- Lives are never decremented below 0.
- `gameover = &dead`, registered.
- Restart:
  - All players go to ALIVE with lives = LIVES and holdoff = 0.
  - `OutBUS` goes to all 1s; `hit`, `dead` and `gameover` go to 0.
  - Restart has priority over a tick in the same cycle; that tick is discarded.
- Players never interact. Simultaneous hits on several players in one tick are all processed in that tick.

## Timing

- All outputs are registered. Latency is 1 clock: a tick sampled at edge N is reflected in every output after edge N.
- `hit` is high for exactly one clock per lost life. Ticks on consecutive clocks are legal and each is processed.
- `fila0` and `posjug` need to be valid only in the tick cycle.
- Asynchronous reset values: FSM ALIVE, lives = LIVES, holdoff = 0, `OutBUS` all 1s, `hit` 0, `dead` 0, `gameover` 0.
- Reset asserted mid-operation (for example during HOLD) forces these values immediately, without a clock edge. Deassertion is taken at the next edge.

## Configuration

- `CC_COLLISION_HOLDOFF_EN`
  - Defined: the HOLD state and holdoff counter exist, behaving as above.
  - Undefined: HOLD and the holdoff counter are not built, `HOLDOFF` is unused, and every overlapping tick in ALIVE costs a life.

## Test plan

All scenarios use the defaults (8, 2, 4, 7, 3, 4).

- **Reset:** hold reset low with the clock stopped, then release. Required: `OutBUS`=2'b11, `lives`=3/3, `hit`=0, `dead`=0, `gameover`=0.
- **Out-of-window overlap:** `fila0`=8'h0F, pos0=8'h01, tick. Required: `OutBUS[0]`=1, no hit, `lives0`=3.
- **In-window hit:** `fila0`=8'hF0, pos0=8'h10, pos1=8'h01, tick. Required one clock later: `hit`=2'b01 for one cycle, `lives0`=2, `OutBUS`=2'b10, `lives1`=3.
- **Holdoff:** keep the overlap for 4 more ticks. Required with the macro: no hit, `lives0`=2 throughout, then the 5th tick gives `hit[0]` and `lives0`=1. Required without the macro: a hit on each tick, with `dead[0]`=1 after the 3rd total hit.
- **Game over, then restart:** drive both players to 0 lives. Required: `dead`=2'b11, `gameover`=1, further ticks change nothing. Then assert restart together with an overlapping tick. Required: `lives`=3/3, `gameover`=0, no hit pulse.
- **Reset mid-HOLD:** assert reset in the middle of HOLD. Required: outputs reach their reset values asynchronously, and the first tick after release with overlap produces an immediate hit.
